// File: rtl/sincos_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sincos_rom_arbiter
// Purpose  : Round-robin arbiter that shares one registered cos_sine ROM among
//            NREQ requesters. It issues the winning phase to the ROM and uses
//            a tag pipeline matched to ROM_LAT to steer each result back to
//            the requester that asked for it.
// Options  : SINCOS_BURST_EN - when defined, the current owner keeps the
//            grant for up to BURST_MAX consecutive cycles while it requests.
// Revision : 1.0 - initial release
// ============================================================================
module sincos_rom_arbiter #(
  parameter int NREQ      = 4,
  parameter int XW        = 10,
  parameter int YW        = 8,
  parameter int ROM_LAT   = 1,
  parameter int BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*XW-1:0] x_in,
  output logic [NREQ-1:0]    gnt,
  output logic [XW-1:0]      rom_x,
  input  logic [YW-1:0]      rom_sine,
  input  logic [YW-1:0]      rom_cos,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [YW-1:0]      rsp_sine,
  output logic [YW-1:0]      rsp_cos
);

  localparam int              C_PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              C_LAST    = ROM_LAT;  // index of the final tag stage
  localparam logic [C_PW-1:0] C_MAX_IDX = C_PW'(NREQ - 1);

  logic [C_PW-1:0]             r_ptr;
  logic [C_PW-1:0]             w_ptr_nxt;
  logic [C_PW-1:0]             w_gnt_idx;
  logic [C_PW-1:0]             w_idx_inc;
  logic                        w_gnt_any;
  logic [C_LAST:0]             r_tag_v;
  logic [C_LAST:0][C_PW-1:0]   r_tag_id;

  // Reject illegal configurations at elaboration time
  generate
    if (NREQ < 2 || NREQ > 8 || BURST_MAX < 1) begin : g_param_check
      $error("sincos_rom_arbiter: NREQ must be 2..8 and BURST_MAX >= 1");
    end
  endgenerate

  // Round-robin search: first active request at or after r_ptr, wrapping
  always_comb begin
    logic [C_PW-1:0] v_idx;
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    v_idx     = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_gnt_any && req[v_idx]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = v_idx;
      end
      v_idx = (v_idx == C_MAX_IDX) ? '0 : v_idx + C_PW'(1);
    end
  end

  assign gnt       = w_gnt_any ? (NREQ'(1) << w_gnt_idx) : '0;
  assign w_idx_inc = (w_gnt_idx == C_MAX_IDX) ? '0 : w_gnt_idx + C_PW'(1);

`ifdef SINCOS_BURST_EN
  localparam int              C_CW        = $clog2(BURST_MAX) + 1;
  localparam logic [C_CW-1:0] C_BURST_MAX = C_CW'(BURST_MAX);

  logic [C_CW-1:0] r_burst_cnt;
  logic [C_CW-1:0] w_burst_nxt;
  logic [C_CW-1:0] w_run;

  // Pointer parks on the owner until its burst is used up or it lets go
  always_comb begin
    w_run       = (w_gnt_idx == r_ptr) ? r_burst_cnt + C_CW'(1) : C_CW'(1);
    w_ptr_nxt   = r_ptr;
    w_burst_nxt = r_burst_cnt;
    if (w_gnt_any) begin
      if (w_run >= C_BURST_MAX) begin
        w_ptr_nxt   = w_idx_inc;
        w_burst_nxt = '0;
      end else begin
        w_ptr_nxt   = w_gnt_idx;
        w_burst_nxt = w_run;
      end
    end else if (r_burst_cnt != '0) begin
      // Owner dropped its request and nobody else is waiting
      w_ptr_nxt   = (r_ptr == C_MAX_IDX) ? '0 : r_ptr + C_PW'(1);
      w_burst_nxt = '0;
    end
  end

  // Burst length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst_cnt <= '0;
    end else begin
      r_burst_cnt <= w_burst_nxt;
    end
  end
`else
  // Pure round-robin: move past every winner
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_gnt_any) begin
      w_ptr_nxt = w_idx_inc;
    end
  end
`endif

  // Pointer register and phase issue to the ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      rom_x <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_gnt_any) begin
        rom_x <= x_in[w_gnt_idx*XW +: XW];
      end
    end
  end

  // Tag pipeline tracks the owner of each lookup while it is inside the ROM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= w_gnt_any;
      r_tag_id[0] <= w_gnt_idx;
      for (int s = 1; s <= C_LAST; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // Capture the ROM result and flag its owner for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_sine  <= '0;
      rsp_cos   <= '0;
    end else begin
      rsp_valid <= r_tag_v[C_LAST] ? (NREQ'(1) << r_tag_id[C_LAST]) : '0;
      if (r_tag_v[C_LAST]) begin
        rsp_sine <= rom_sine;
        rsp_cos  <= rom_cos;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sincos_rom_arbiter.md
Name: sincos_rom_arbiter

Overview:
- Shares one cos_sine ROM lookup (10-bit phase in, 8-bit sine/cos out, registered) among NREQ requesters.
- Round-robin arbitration with a valid/req-grant handshake.
- Drives the ROM phase input, then routes each ROM result back to the requester that issued it, using a tag pipeline matched to the ROM latency.
- Sits between the waveform generators (DDS/sweep channels) and the single shared cos_sine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- XW, 10, phase width; must match the cos_sine x input.
- YW, 8, output sample width; must match y_sine/y_cos.
- ROM_LAT, 1, clock cycles from rom_x change to valid rom_sine/rom_cos.
- BURST_MAX, 4, maximum consecutive grants to one requester; used only with SINCOS_BURST_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester lookup request; held high until granted.
- x_in  in  NREQ*XW  packed phases; requester i uses bits [i*XW +: XW].
- gnt  out  NREQ  one-hot combinational grant; a transfer occurs in any cycle where req[i]&gnt[i].
- rom_x  out  XW  registered phase driven to the cos_sine x input.
- rom_sine  in  YW  from cos_sine y_sine.
- rom_cos  in  YW  from cos_sine y_cos.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse marking the response owner.
- rsp_sine  out  YW  registered sine result, shared bus.
- rsp_cos  out  YW  registered cosine result, shared bus.

Behaviour:
- Reset (async assert, sync release):
  - rom_x=0, rsp_valid=0, rsp_sine=0, rsp_cos=0.
  - Round-robin pointer ptr=0.
  - Tag pipeline cleared; in-flight lookups are discarded and produce no rsp_valid after reset.
- Arbitration (combinational):
  - gnt = first set bit of req, searching from index ptr upward with wrap to 0.
  - gnt=0 when req=0.
  - gnt is at most one-hot and never asserted for a deasserted req.
- Pointer update (registered), on any cycle with a grant to index k: ptr <= (k+1) mod NREQ. No grant leaves ptr unchanged.
- Issue:
  - Grant cycle T: rom_x <= x_in slice k at the T edge.
  - No grant: rom_x holds its value. The ROM free-runs and the result is ignored.
- Tag pipeline:
  - ROM_LAT+1 stages of {valid, owner index}.
  - Stage 0 is loaded at the same edge as rom_x.
- Response:
  - When the last tag stage is valid, register rom_sine/rom_cos into rsp_sine/rsp_cos and pulse rsp_valid[owner] for one cycle.
  - Total latency is grant cycle T to rsp_valid at cycle T+ROM_LAT+2. With ROM_LAT=1 that is T+3.
  - rsp_sine/rsp_cos hold their last value when rsp_valid=0.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants yield back-to-back responses in grant order.
- Same requester re-requesting: allowed every cycle. It receives a grant only when round-robin reaches it again, unless SINCOS_BURST_EN is defined.
- Fairness: with all NREQ requesters continuously active, each is granted exactly once every NREQ cycles.
- Wrap-around: the pointer goes from NREQ-1 to 0.

Optional Feature:
- Macro: SINCOS_BURST_EN.
- Defined:
  - A burst counter (width clog2(BURST_MAX)+1) keeps the grant on the current owner while its req stays high, up to BURST_MAX consecutive grants.
  - After that, or when the owner drops req, ptr advances to owner+1 and the counter resets to 0.
  - The counter resets to 0 on rst_n.
- Undefined: no counter; ptr advances after every grant (pure round-robin as above).

Test Plan:
- Reset check:
  - Assert rst_n=0 mid-stream with 3 lookups in flight; release.
  - Required: rsp_valid stays 0 until new grants are made; rom_x=0; first grant goes to the lowest active index ≥0.
- Single requester:
  - req=4'b0001 for one cycle with x=256.
  - Required: gnt=0001 that cycle; rom_x=256 next cycle; rsp_valid=0001 at T+3; rsp_sine/rsp_cos equal a reference cos_sine instance driven with x=256.
- All requesters continuous:
  - req=4'b1111 with x0..x3 = 0, 256, 512, 768.
  - Required: grant order 0,1,2,3,0,…; responses in the same order with the matching ROM values; one rsp_valid per cycle.
- Sparse/wrap:
  - ptr=3, req=4'b0101.
  - Required: gnt=0001, then ptr=1 and the next grant goes to 2.
  - If req=4'b0010 while ptr=3, gnt=0010.
- Sweep:
  - Requester 2 steps x 0..1023 (counter driven), other requesters idle.
  - Required: 1024 responses, each matching the reference cos_sine output for the same x; no drops across the 1023→0 wrap.
- Burst (SINCOS_BURST_EN, BURST_MAX=4):
  - req=4'b0011 held.
  - Required: grants 0,0,0,0,1,1,1,1,0,…
  - Without the macro: 0,1,0,1,…
